// File: rtl/lrsc_pkg.sv
// Shared types and constants for the LR/SC reservation tracker.
package lrsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_OPEN = 2'd2
  } lrsc_state_e;

  localparam int unsigned DEF_ADDR_W    = 48;
  localparam int unsigned DEF_GRAN_BITS = 6;
  localparam int unsigned DEF_TIMEOUT   = 80;
  localparam int unsigned DEF_HOLD      = 16;

  // Granule tag of a zero-extended address; callers compare whole results.
  function automatic logic [63:0] granule_tag(input logic [63:0] addr, input int unsigned gran_bits);
    return addr >> gran_bits;
  endfunction

endpackage

// File: rtl/lrsc_event_gen_if.sv
// Request/response, probe, flush and difftest event signals of lrsc_event_gen.
interface lrsc_event_gen_if #(
  parameter int unsigned ADDR_W = 48
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_lr;
  logic              req_is_sc;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_sc_fail;
  logic              inv_valid;
  logic              inv_ready;
  logic [ADDR_W-1:0] inv_addr;
  logic              flush;
  logic [7:0]        coreid;
  logic              evt_valid;
  logic              evt_success;
  logic [7:0]        evt_coreid;

  modport master (
    output req_valid, req_is_lr, req_is_sc, req_addr, inv_valid, inv_addr, flush, coreid,
    input  req_ready, resp_valid, resp_sc_fail, inv_ready, evt_valid, evt_success, evt_coreid
  );

  modport slave (
    input  req_valid, req_is_lr, req_is_sc, req_addr, inv_valid, inv_addr, flush, coreid,
    output req_ready, resp_valid, resp_sc_fail, inv_ready, evt_valid, evt_success, evt_coreid
  );
endinterface

// File: rtl/lrsc_timer.sv
// Loadable down-counter tracking reservation lifetime and the probe-refusal window.
module lrsc_timer #(
  parameter int unsigned TIMEOUT = 80,
  parameter int unsigned HOLD    = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic expired,
  output logic held
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_r;

  // Count register: clear wins over load, otherwise saturate at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (load) begin
      count_r <= CW'(TIMEOUT);
    end else if (count_r != {CW{1'b0}}) begin
      count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {CW{1'b0}});
  assign held    = (count_r > CW'(TIMEOUT - HOLD));

endmodule

// File: rtl/lrsc_event_gen.sv
// LR/SC reservation tracker resolving SC outcome and producing the difftest LR/SC event.
// Define DIFFTEST_LRSC_EN to build the event registers; otherwise io.evt_* are tied low.
module lrsc_event_gen
  import lrsc_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned GRAN_BITS = DEF_GRAN_BITS,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned HOLD      = DEF_HOLD
) (
  input logic             clock,
  input logic             reset,
  lrsc_event_gen_if.slave io
);
  localparam int unsigned TAG_W = ADDR_W - GRAN_BITS;

  logic [TAG_W-1:0] tag_r;
  logic             req_ready_r;
  logic             resp_valid_r;
  logic             resp_sc_fail_r;
  logic             expired_s;
  logic             held_s;
  lrsc_state_e      state_s;
  logic             inv_ready_s;
  logic             resv_valid_s;
  logic             lr_acc_s;
  logic             sc_acc_s;
  logic             inv_hit_s;
  logic             sc_hit_s;
  logic             kill_s;
  logic             sc_ok_s;
  logic             timer_load_s;
  logic             timer_clear_s;

  lrsc_timer #(
    .TIMEOUT (TIMEOUT),
    .HOLD    (HOLD)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load_s),
    .clear   (timer_clear_s),
    .expired (expired_s),
    .held    (held_s)
  );

  // Reservation state is decoded from the lifetime counter.
  always_comb begin
    state_s = ST_IDLE;
    if (expired_s) begin
      state_s = ST_IDLE;
    end else if (held_s) begin
      state_s = ST_HELD;
    end else begin
      state_s = ST_OPEN;
    end
  end

  // Acceptance, match and priority resolution: flush > matching probe > LR.
  always_comb begin
    resv_valid_s  = 1'b0;
    inv_ready_s   = 1'b1;
    lr_acc_s      = 1'b0;
    sc_acc_s      = 1'b0;
    inv_hit_s     = 1'b0;
    sc_hit_s      = 1'b0;
    kill_s        = 1'b0;
    sc_ok_s       = 1'b0;
    timer_load_s  = 1'b0;
    timer_clear_s = 1'b0;
    case (state_s)
      ST_IDLE: begin
        resv_valid_s = 1'b0;
        inv_ready_s  = 1'b1;
      end
      ST_HELD: begin
        resv_valid_s = 1'b1;
        inv_ready_s  = 1'b0;
      end
      ST_OPEN: begin
        resv_valid_s = 1'b1;
        inv_ready_s  = 1'b1;
      end
      default: begin
        resv_valid_s = 1'b0;
        inv_ready_s  = 1'b1;
      end
    endcase
    lr_acc_s  = io.req_valid & req_ready_r & io.req_is_lr & ~io.req_is_sc;
    sc_acc_s  = io.req_valid & req_ready_r & io.req_is_sc & ~io.req_is_lr;
    inv_hit_s = io.inv_valid & inv_ready_s & resv_valid_s &
                (64'(tag_r) == granule_tag(64'(io.inv_addr), GRAN_BITS));
    sc_hit_s  = resv_valid_s & (64'(tag_r) == granule_tag(64'(io.req_addr), GRAN_BITS));
    kill_s        = io.flush | inv_hit_s;
    sc_ok_s       = sc_acc_s & sc_hit_s & ~kill_s;
    timer_clear_s = kill_s | sc_acc_s;
    timer_load_s  = lr_acc_s & ~kill_s;
  end

  // Reservation tag and request-ready registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_r       <= {TAG_W{1'b0}};
      req_ready_r <= 1'b0;
    end else begin
      req_ready_r <= 1'b1;
      if (timer_load_s) begin
        tag_r <= io.req_addr[ADDR_W-1:GRAN_BITS];
      end else begin
        tag_r <= tag_r;
      end
    end
  end

  // SC response pulse, one cycle after acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid_r   <= 1'b0;
      resp_sc_fail_r <= 1'b0;
    end else begin
      resp_valid_r   <= sc_acc_s;
      resp_sc_fail_r <= sc_acc_s & ~sc_ok_s;
    end
  end

  assign io.req_ready    = req_ready_r;
  assign io.resp_valid   = resp_valid_r;
  assign io.resp_sc_fail = resp_sc_fail_r;
  assign io.inv_ready    = inv_ready_s;

`ifdef DIFFTEST_LRSC_EN
  logic       evt_valid_r;
  logic       evt_success_r;
  logic [7:0] evt_coreid_r;

  // Difftest event registers; core id captured at SC acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      evt_valid_r   <= 1'b0;
      evt_success_r <= 1'b0;
      evt_coreid_r  <= 8'h00;
    end else begin
      evt_valid_r   <= sc_acc_s;
      evt_success_r <= sc_ok_s;
      if (sc_acc_s) begin
        evt_coreid_r <= io.coreid;
      end else begin
        evt_coreid_r <= evt_coreid_r;
      end
    end
  end

  assign io.evt_valid   = evt_valid_r;
  assign io.evt_success = evt_success_r;
  assign io.evt_coreid  = evt_coreid_r;
`else
  logic unused_coreid_s;
  assign unused_coreid_s = ^io.coreid;
  assign io.evt_valid    = 1'b0;
  assign io.evt_success  = 1'b0;
  assign io.evt_coreid   = 8'h00;
`endif

endmodule
